// File: rtl/ahb_pkg.sv
// Shared AHB transfer/burst encodings and the burst-length helper used by the
// master multiplexer and its beat counter.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    // Number of beats in a fixed-length burst; 0 marks the unbounded INCR burst.
    function automatic logic [4:0] burst_len(hburst_t burst);
        burst_len = 5'd0;
        case (burst)
            SINGLE:          burst_len = 5'd1;
            INCR:            burst_len = 5'd0;
            WRAP4, INCR4:    burst_len = 5'd4;
            WRAP8, INCR8:    burst_len = 5'd8;
            WRAP16, INCR16:  burst_len = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Tracks the beat index of the address-phase burst and detects SEQ transfers
// that do not continue a legal burst of the same master.
module ahb_beat_counter
    import ahb_pkg::*;
#(
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hready_i,
    input  logic [1:0]    htrans_i,
    input  logic [2:0]    hburst_i,
    input  logic [MW-1:0] hmaster_i,
    input  logic [MW-1:0] hmasterD_i,
    input  logic          prevIdle_i,
    output logic [3:0]    beat_o,
    output logic          burstLast_o,
    output logic          seqViol_o
);

    logic [3:0] beatCnt_q;
    logic [3:0] beatCnt_d;
    logic [4:0] burstLen;
    logic       active;
    htrans_t    trans;
    hburst_t    burst;

    // A NONSEQ is always beat 0; the counter already points at the next beat.
    always_comb begin
        trans       = htrans_t'(htrans_i);
        burst       = hburst_t'(hburst_i);
        burstLen    = burst_len(burst);
        active      = (trans == NONSEQ) || (trans == SEQ);
        beat_o      = (trans == NONSEQ) ? 4'd0 : beatCnt_q;
        burstLast_o = active && (burstLen != 5'd0) && ({1'b0, beat_o} == burstLen - 5'd1);
        seqViol_o   = (trans == SEQ) &&
                      (prevIdle_i || (hmaster_i != hmasterD_i) ||
                       ((burstLen != 5'd0) && ({1'b0, beatCnt_q} >= burstLen)));

        beatCnt_d = beatCnt_q;
        if (hready_i) begin
            case (trans)
                IDLE:   beatCnt_d = 4'd0;
                BUSY:   beatCnt_d = beatCnt_q;
                NONSEQ: beatCnt_d = 4'd1;
                SEQ:    beatCnt_d = beatCnt_q + 4'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beatCnt_q <= 4'd0;
        end else begin
            beatCnt_q <= beatCnt_d;
        end
    end

endmodule

// File: rtl/ahb_master_mux.sv
// Routes the granted master's address/control onto the shared AHB bus, follows
// the data-phase owner for write data, and flags burst/lock protocol misuse.
module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 16,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    localparam int MW         = $clog2(NUM_MASTERS)
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [MW-1:0]                 HMASTER,
    input  logic                          HMASTLOCK,
    input  logic                          HREADY,
    input  logic [NUM_MASTERS*2-1:0]      HTRANSx,
    input  logic [NUM_MASTERS*ADDR_W-1:0] HADDRx,
    input  logic [NUM_MASTERS-1:0]        HWRITEx,
    input  logic [NUM_MASTERS*3-1:0]      HSIZEx,
    input  logic [NUM_MASTERS*3-1:0]      HBURSTx,
    input  logic [NUM_MASTERS*DATA_W-1:0] HWDATAx,
    output logic [1:0]                    HTRANS,
    output logic [ADDR_W-1:0]             HADDR,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [DATA_W-1:0]             HWDATA,
    output logic [MW-1:0]                 HMASTER_D,
    output logic                          DATA_VALID,
    output logic [3:0]                    BEAT,
    output logic                          BURST_LAST,
    output logic                          SEQ_ERR
);

    logic [MW-1:0] sel;
    htrans_t       transSel;
    logic [MW-1:0] hmasterD_q, hmasterD_d;
    logic          dataValid_q, dataValid_d;
    logic          prevIdle_q, prevIdle_d;
    logic          seqErr_q, seqErr_d;
    logic          lockViol;
    logic          seqViol;

    // While reset is held the bus shows master 0 with the transfer forced to IDLE.
    always_comb begin
        sel      = HRESETn ? HMASTER : '0;
        transSel = HRESETn ? htrans_t'(HTRANSx[sel*2 +: 2]) : IDLE;
        HTRANS   = transSel;
        HADDR    = HADDRx[sel*ADDR_W +: ADDR_W];
        HWRITE   = HWRITEx[sel];
        HSIZE    = HSIZEx[sel*3 +: 3];
        HBURST   = HBURSTx[sel*3 +: 3];
        HWDATA   = dataValid_q ? HWDATAx[hmasterD_q*DATA_W +: DATA_W] : '0;
    end

    ahb_beat_counter #(
        .MW (MW)
    ) u_beat_counter (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .hready_i    (HREADY),
        .htrans_i    (transSel),
        .hburst_i    (HBURST),
        .hmaster_i   (HMASTER),
        .hmasterD_i  (hmasterD_q),
        .prevIdle_i  (prevIdle_q),
        .beat_o      (BEAT),
        .burstLast_o (BURST_LAST),
        .seqViol_o   (seqViol)
    );

    // The error flag is a single-cycle pulse, so it clears on any stalled edge.
    always_comb begin
        lockViol    = HMASTLOCK && (HMASTER != hmasterD_q) && !prevIdle_q;
        hmasterD_d  = hmasterD_q;
        dataValid_d = dataValid_q;
        prevIdle_d  = prevIdle_q;
        seqErr_d    = 1'b0;
        if (HREADY) begin
            hmasterD_d  = HMASTER;
            dataValid_d = (transSel == NONSEQ) || (transSel == SEQ);
            prevIdle_d  = (transSel == IDLE);
            seqErr_d    = seqViol || lockViol;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hmasterD_q  <= '0;
            dataValid_q <= 1'b0;
            prevIdle_q  <= 1'b1;
            seqErr_q    <= 1'b0;
        end else begin
            hmasterD_q  <= hmasterD_d;
            dataValid_q <= dataValid_d;
            prevIdle_q  <= prevIdle_d;
            seqErr_q    <= seqErr_d;
        end
    end

    assign HMASTER_D  = hmasterD_q;
    assign DATA_VALID = dataValid_q;
    assign SEQ_ERR    = seqErr_q;

endmodule
